alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_ctrl_decode.sv | 42 ++++
 rtl/alu_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, opcodes and controller state encoding
package alu_pkg;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_AND  = 4'b0010;
  localparam logic [3:0] FN_OR   = 4'b0011;
  localparam logic [3:0] FN_XOR  = 4'b0100;
  localparam logic [3:0] FN_NOR  = 4'b0101;
  localparam logic [3:0] FN_SLT  = 4'b0110;
  localparam logic [3:0] FN_SLL  = 4'b0111;
  localparam logic [3:0] FN_SRL  = 4'b1000;
  localparam logic [3:0] FN_SRA  = 4'b1001;
  localparam logic [3:0] FN_MUL  = 4'b1010;
  localparam logic [3:0] FN_MULH = 4'b1011;
  localparam logic [3:0] FN_DIV  = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational instruction field decode for alu_ctrl
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic        legal,
  output logic [3:0]  func,
  output logic        imm_sel,
  output logic [4:0]  dest,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  shamt,
  output logic [31:0] imm
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign shamt  = instr[10:6];
  assign imm    = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    legal   = 1'b0;
    func    = FN_ADD;
    imm_sel = 1'b0;
    dest    = 5'd0;
    if (opcode == OP_RTYPE && funct[5:4] == 2'b00 && funct[3:0] <= FN_DIV) begin
      legal = 1'b1;
      func  = funct[3:0];
      dest  = instr[15:11];
    end else if (opcode == OP_ADDI) begin
      legal   = 1'b1;
      imm_sel = 1'b1;
      dest    = instr[20:16];
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - ALU sequencing FSM (IDLE/DECODE/EXEC/WB); ALU_CTRL_PERF_CNT_EN adds retired count
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] alu_result,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [3:0]  alu_func,
  output logic [4:0]  alu_shamt,
  output logic        imm_sel,
  output logic [31:0] imm,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal,
`ifdef ALU_CTRL_PERF_CNT_EN
  output logic [31:0] retired,
`endif
  output logic        busy
);

  // Counter holds remaining EXEC cycles after the current one.
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

  state_t      state;
  logic [31:0] instr_q;
  logic [7:0]  cnt;
  logic        accept;

  logic        dec_legal;
  logic [3:0]  dec_func;
  logic        dec_imm_sel;
  logic [4:0]  dec_dest;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_shamt;
  logic [31:0] dec_imm;

  alu_ctrl_decode u_decode (
    .instr   (instr_q),
    .legal   (dec_legal),
    .func    (dec_func),
    .imm_sel (dec_imm_sel),
    .dest    (dec_dest),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .shamt   (dec_shamt),
    .imm     (dec_imm)
  );

  assign accept  = instr_valid && instr_ready;
  assign illegal = (state == S_DECODE) && !dec_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      cnt         <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      rs_addr     <= '0;
      rt_addr     <= '0;
      alu_func    <= '0;
      alu_shamt   <= '0;
      imm_sel     <= 1'b0;
      imm         <= '0;
      wb_en       <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
`ifdef ALU_CTRL_PERF_CNT_EN
      retired     <= '0;
`endif
    end else begin
      wb_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            instr_q     <= instr;
            state       <= S_DECODE;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_DECODE: begin
          if (!dec_legal) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            rs_addr   <= dec_rs;
            rt_addr   <= dec_rt;
            alu_func  <= dec_func;
            alu_shamt <= dec_shamt;
            imm_sel   <= dec_imm_sel;
            imm       <= dec_imm;
            wb_addr   <= dec_dest;
            cnt       <= (dec_func == FN_DIV) ? DIV_CNT : 8'd0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == 8'd0) begin
            wb_data     <= alu_result;
            wb_en       <= (wb_addr != 5'd0);
            state       <= S_WB;
            instr_ready <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_WB: begin
`ifdef ALU_CTRL_PERF_CNT_EN
          retired <= retired + 32'd1;
`endif
          if (accept) begin
            instr_q     <= instr;
            state       <= S_DECODE;
            instr_ready <= 1'b0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - directed self-checking bench for alu_ctrl
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] alu_result;
  logic [4:0]  rs_addr, rt_addr, alu_shamt, wb_addr;
  logic [3:0]  alu_func;
  logic        imm_sel, wb_en, illegal, busy;
  logic [31:0] imm, wb_data;
`ifdef ALU_CTRL_PERF_CNT_EN
  logic [31:0] retired;
`endif

  int checks = 0;
  int fails  = 0;

  alu_ctrl #(.DIV_LAT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_result  (alu_result),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .alu_func    (alu_func),
    .alu_shamt   (alu_shamt),
    .imm_sel     (imm_sel),
    .imm         (imm),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal     (illegal),
`ifdef ALU_CTRL_PERF_CNT_EN
    .retired     (retired),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] k);
    return {6'h01, rs, rt, k};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = '0; instr_valid = 1'b0; alu_result = '0;
    tick(); tick();
    checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({wb_en, illegal, imm_sel} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {wb_en, illegal, imm_sel}); end
    checks++; if ({wb_data, imm} !== 64'h0) begin fails++; $display("FAIL reset_data: got %h want 0", {wb_data, imm}); end
    checks++; if ({rs_addr, rt_addr, wb_addr, alu_shamt, alu_func} !== 24'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", {rs_addr, rt_addr, wb_addr, alu_shamt, alu_func}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    alu_result = 32'd5;
    instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h00); instr_valid = 1'b1;
    tick();                                  // cycle 1: DECODE
    instr_valid = 1'b0;
    checks++; if ({busy, instr_ready, illegal} !== 3'b100) begin fails++; $display("FAIL add_decode: got %b want 100", {busy, instr_ready, illegal}); end
    tick();                                  // cycle 2: EXEC
    checks++; if (alu_func !== 4'b0000) begin fails++; $display("FAIL add_func: got %h want 0", alu_func); end
    checks++; if ({rs_addr, rt_addr, imm_sel} !== {5'd1, 5'd2, 1'b0}) begin fails++; $display("FAIL add_operands: got %h want %h", {rs_addr, rt_addr, imm_sel}, {5'd1, 5'd2, 1'b0}); end
    checks++; if (wb_en !== 1'b0) begin fails++; $display("FAIL add_early_wb: got %b want 0", wb_en); end
    tick();                                  // cycle 3: WB
    checks++; if (wb_en !== 1'b1) begin fails++; $display("FAIL add_wb_en: got %b want 1", wb_en); end
    checks++; if (wb_addr !== 5'd3) begin fails++; $display("FAIL add_wb_addr: got %0d want 3", wb_addr); end
    checks++; if (wb_data !== 32'd5) begin fails++; $display("FAIL add_wb_data: got %h want 5", wb_data); end
    checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL add_wb_ready: got %b want 1", instr_ready); end
    tick();
    checks++; if ({wb_en, busy} !== 2'b00) begin fails++; $display("FAIL add_idle: got %b want 00", {wb_en, busy}); end
  endtask

  task automatic test_div();
    alu_result = 32'h0000_1234;
    instr = rtype(5'd4, 5'd5, 5'd6, 5'd0, 6'h0C); instr_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      instr_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL div_busy c%0d: got %b want 1", c, busy); end
      checks++; if (instr_ready !== (c == 10)) begin fails++; $display("FAIL div_ready c%0d: got %b want %b", c, instr_ready, c == 10); end
      checks++; if (wb_en !== (c == 10)) begin fails++; $display("FAIL div_wb_en c%0d: got %b want %b", c, wb_en, c == 10); end
      if (c >= 2 && c <= 9) begin
        checks++; if (alu_func !== 4'b1100) begin fails++; $display("FAIL div_func c%0d: got %h want c", c, alu_func); end
      end
    end
    checks++; if ({wb_addr, wb_data} !== {5'd6, 32'h0000_1234}) begin fails++; $display("FAIL div_wb: got %h want %h", {wb_addr, wb_data}, {5'd6, 32'h0000_1234}); end
    tick();
    checks++; if ({busy, wb_en} !== 2'b00) begin fails++; $display("FAIL div_done: got %b want 00", {busy, wb_en}); end
  endtask

  task automatic test_illegal(input logic [31:0] bad);
    instr = bad; instr_valid = 1'b1;
    tick();                                  // cycle 1
    instr_valid = 1'b0;
    checks++; if (illegal !== 1'b1) begin fails++; $display("FAIL ill_pulse %h: got %b want 1", bad, illegal); end
    tick();                                  // cycle 2
    checks++; if ({illegal, instr_ready, busy} !== 3'b010) begin fails++; $display("FAIL ill_after %h: got %b want 010", bad, {illegal, instr_ready, busy}); end
    for (int c = 3; c <= 5; c++) begin
      tick();
      checks++; if (wb_en !== 1'b0) begin fails++; $display("FAIL ill_wb c%0d: got %b want 0", c, wb_en); end
    end
  endtask

  task automatic test_addi_zero();
    alu_result = 32'hDEAD_BEEF;
    instr = addi(5'd7, 5'd0, 16'hFFFF); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();                                  // EXEC
    checks++; if (imm !== 32'hFFFF_FFFF) begin fails++; $display("FAIL addi_imm: got %h want ffffffff", imm); end
    checks++; if ({imm_sel, alu_func, rs_addr} !== {1'b1, 4'b0000, 5'd7}) begin fails++; $display("FAIL addi_ctrl: got %h want %h", {imm_sel, alu_func, rs_addr}, {1'b1, 4'b0000, 5'd7}); end
    tick();                                  // WB to r0
    checks++; if ({busy, instr_ready, wb_en} !== 3'b110) begin fails++; $display("FAIL addi_r0_wb: got %b want 110", {busy, instr_ready, wb_en}); end
    tick();
    checks++; if (wb_en !== 1'b0) begin fails++; $display("FAIL addi_r0_after: got %b want 0", wb_en); end
  endtask

  task automatic test_reset_mid_div();
    alu_result = 32'h55;
    instr = rtype(5'd1, 5'd1, 5'd8, 5'd0, 6'h0C); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int c = 2; c <= 5; c++) tick();    // fourth EXEC cycle
    rst = 1'b1;
    #1;
    checks++; if ({busy, instr_ready, wb_en, alu_func} !== {3'b010, 4'h0}) begin fails++; $display("FAIL rst_mid: got %h want %h", {busy, instr_ready, wb_en, alu_func}, {3'b010, 4'h0}); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if ({wb_en, busy} !== 2'b00) begin fails++; $display("FAIL rst_discard c%0d: got %b want 00", c, {wb_en, busy}); end
    end
    alu_result = 32'd3;
    instr = addi(5'd0, 5'd9, 16'd3); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd9, 32'd3}) begin fails++; $display("FAIL rst_recover: got %h want %h", {wb_en, wb_addr, wb_data}, {1'b1, 5'd9, 32'd3}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_addr [3];
`ifdef ALU_CTRL_PERF_CNT_EN
    logic [31:0] r0;
    r0 = retired;
`endif
    exp_addr[0] = 5'd10; exp_addr[1] = 5'd11; exp_addr[2] = 5'd12;
    alu_result = 32'h77;
    instr = rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h00); instr_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) instr = addi(5'd3, 5'd11, 16'h0010);
      if (c == 4) instr = rtype(5'd3, 5'd4, 5'd12, 5'd2, 6'h01);
      if (c == 7) instr_valid = 1'b0;
      checks++; if (wb_en !== (c % 3 == 0 && c <= 9)) begin fails++; $display("FAIL b2b_wb_en c%0d: got %b want %b", c, wb_en, c % 3 == 0 && c <= 9); end
      if (c % 3 == 0 && c <= 9) begin
        checks++; if ({wb_addr, wb_data} !== {exp_addr[c/3-1], 32'h77}) begin fails++; $display("FAIL b2b_wb c%0d: got %h want %h", c, {wb_addr, wb_data}, {exp_addr[c/3-1], 32'h77}); end
      end
      if (c <= 9) begin
        checks++; if (instr_ready !== (c % 3 == 0)) begin fails++; $display("FAIL b2b_ready c%0d: got %b want %b", c, instr_ready, c % 3 == 0); end
      end
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", busy); end
`ifdef ALU_CTRL_PERF_CNT_EN
    checks++; if (retired !== r0 + 32'd3) begin fails++; $display("FAIL b2b_retired: got %0d want %0d", retired, r0 + 32'd3); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_illegal({6'h3F, 26'h0});
    test_illegal(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h0D));
    test_addi_zero();
    test_reset_mid_div();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
